// File: rtl/card_pair_matcher.sv
`default_nettype none
// ============================================================================
// Module      : card_pair_matcher
// Description : Memory-game pair logic. Tracks per-card active/revealed
//               masks, fetches card symbols from the deck memory, compares
//               each revealed pair, holds it visible, then removes or hides
//               it. Counts pairs and moves and flags game over.
// Revision    : 1.0 - initial release
// ============================================================================
module card_pair_matcher #(
    parameter int NUM_MAX    = 18,
    parameter int ADDR_W     = 5,
    parameter int SYM_W      = 4,
    parameter int HIDE_DELAY = 65_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  num_of_cards,
    input  logic               event_occurred,
    input  logic [ADDR_W-1:0]  card_clicked_address,
    input  logic [ADDR_W-1:0]  card_to_test_address,
    output logic [1:0]         card_test_state,
    output logic               card_press_checker_en,
    output logic [ADDR_W-1:0]  sym_addr,
    input  logic [SYM_W-1:0]   sym_data,
    output logic [NUM_MAX-1:0] active_mask,
    output logic [NUM_MAX-1:0] revealed_mask,
    output logic [3:0]         pairs_found,
    output logic [7:0]         moves,
    output logic               game_over
);

    // Delay counter only needs to hold HIDE_DELAY-1.
    localparam int              CNT_W        = (HIDE_DELAY > 2) ? $clog2(HIDE_DELAY) : 1;
    localparam logic [CNT_W-1:0] C_DELAY_LOAD = CNT_W'(HIDE_DELAY - 1);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_WAIT_FIRST   = 4'd1,
        S_FETCH_FIRST  = 4'd2,
        S_WAIT_SECOND  = 4'd3,
        S_FETCH_SECOND = 4'd4,
        S_COMPARE      = 4'd5,
        S_SHOW         = 4'd6,
        S_RESOLVE      = 4'd7,
        S_DONE         = 4'd8
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [NUM_MAX-1:0] r_active;
    logic [NUM_MAX-1:0] r_revealed;
    logic [NUM_MAX-1:0] r_sel1;        // one-hot of first card (addr1)
    logic [NUM_MAX-1:0] r_sel2;        // one-hot of second card (addr2)
    logic [SYM_W-1:0]   r_sym1;
    logic [SYM_W-1:0]   r_sym2;
    logic               r_match;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_pairs;
    logic [3:0]         r_half;        // pairs needed to finish the game
    logic [7:0]         r_moves;
    logic [ADDR_W-1:0]  r_sym_addr;

    logic [NUM_MAX-1:0] w_click_sel;
    logic [NUM_MAX-1:0] w_init_mask;
    logic               w_test_act;
    logic               w_test_rev;
    logic               w_click_ok;
    logic               w_start_ok;
    logic [3:0]         w_pairs_inc;

    // Address decode for clicks and state queries, plus the new-game mask.
    // Out-of-range addresses decode to no card at all.
    always_comb begin
        w_click_sel = '0;
        w_init_mask = '0;
        w_test_act  = 1'b0;
        w_test_rev  = 1'b0;
        for (int i = 0; i < NUM_MAX; i++) begin
            if (card_clicked_address == ADDR_W'(i + 1)) begin
                w_click_sel[i] = 1'b1;
            end
            if (card_to_test_address == ADDR_W'(i + 1)) begin
                w_test_act = r_active[i];
                w_test_rev = r_revealed[i];
            end
            w_init_mask[i] = (i < int'(num_of_cards));
        end
    end

    assign w_click_ok  = event_occurred && (|(w_click_sel & r_active & ~r_revealed));
    assign w_start_ok  = start && !num_of_cards[0] && (num_of_cards != '0)
                         && (int'(num_of_cards) <= NUM_MAX);
    assign w_pairs_inc = r_match ? (r_pairs + 4'd1) : r_pairs;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start overrides everything, including a click.
    always_comb begin
        w_next_state = r_state;
        if (start) begin
            w_next_state = w_start_ok ? S_WAIT_FIRST : S_IDLE;
        end else begin
            case (r_state)
                S_WAIT_FIRST:   if (w_click_ok) w_next_state = S_FETCH_FIRST;
                S_FETCH_FIRST:  w_next_state = S_WAIT_SECOND;
                S_WAIT_SECOND:  if (w_click_ok) w_next_state = S_FETCH_SECOND;
                S_FETCH_SECOND: w_next_state = S_COMPARE;
                S_COMPARE:      w_next_state = S_SHOW;
                S_SHOW:         if (r_cnt == '0) w_next_state = S_RESOLVE;
                S_RESOLVE:      w_next_state = (w_pairs_inc == r_half) ? S_DONE : S_WAIT_FIRST;
                default:        w_next_state = r_state;
            endcase
        end
    end

    // Board masks, fetched symbols, delay counter and score counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= '0;
            r_revealed <= '0;
            r_sel1     <= '0;
            r_sel2     <= '0;
            r_sym1     <= '0;
            r_sym2     <= '0;
            r_match    <= 1'b0;
            r_cnt      <= '0;
            r_pairs    <= '0;
            r_half     <= '0;
            r_moves    <= '0;
            r_sym_addr <= '0;
        end else if (start) begin
            r_active   <= w_start_ok ? w_init_mask : '0;
            r_revealed <= '0;
            r_pairs    <= '0;
            r_moves    <= '0;
            r_half     <= w_start_ok ? 4'(num_of_cards >> 1) : 4'd0;
        end else begin
            case (r_state)
                S_WAIT_FIRST: begin
                    if (w_click_ok) begin
                        r_revealed <= r_revealed | w_click_sel;
                        r_sel1     <= w_click_sel;
                        r_sym_addr <= card_clicked_address;
                    end
                end
                S_FETCH_FIRST: r_sym1 <= sym_data;
                S_WAIT_SECOND: begin
                    if (w_click_ok) begin
                        r_revealed <= r_revealed | w_click_sel;
                        r_sel2     <= w_click_sel;
                        r_sym_addr <= card_clicked_address;
                    end
                end
                S_FETCH_SECOND: r_sym2 <= sym_data;
                S_COMPARE: begin
                    if (r_moves != 8'hFF) begin
                        r_moves <= r_moves + 8'd1;
                    end
                    r_match <= (r_sym1 == r_sym2);
                    r_cnt   <= C_DELAY_LOAD;
                end
                S_SHOW: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESOLVE: begin
                    r_revealed <= r_revealed & ~(r_sel1 | r_sel2);
                    if (r_match) begin
                        r_active <= r_active & ~(r_sel1 | r_sel2);
                    end
                    r_pairs <= w_pairs_inc;
                end
                default: ;
            endcase
        end
    end

    assign card_test_state       = {w_test_rev, w_test_act};
    assign card_press_checker_en = (r_state == S_WAIT_FIRST) || (r_state == S_WAIT_SECOND);
    assign sym_addr              = r_sym_addr;
    assign active_mask           = r_active;
    assign revealed_mask         = r_revealed;
    assign pairs_found           = r_pairs;
    assign moves                 = r_moves;
    assign game_over             = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_card_pair_matcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_card_pair_matcher
// Description : Self-checking bench for card_pair_matcher with a card-level
//               game model (arrays of active/revealed flags and counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_card_pair_matcher;

    localparam int D   = 4;
    localparam int NUM = 18;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  num_of_cards = '0;
    logic        event_occurred = 1'b0;
    logic [4:0]  card_clicked_address = '0;
    logic [4:0]  card_to_test_address = '0;
    logic [1:0]  card_test_state;
    logic        en;
    logic [4:0]  sym_addr;
    logic [3:0]  sym_data;
    logic [17:0] active_mask;
    logic [17:0] revealed_mask;
    logic [3:0]  pairs_found;
    logic [7:0]  moves;
    logic        game_over;

    logic [3:0]  deck [0:31];
    assign sym_data = deck[sym_addr];

    always #5 clk = ~clk;

    card_pair_matcher #(.NUM_MAX(NUM), .ADDR_W(5), .SYM_W(4), .HIDE_DELAY(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_of_cards(num_of_cards),
        .event_occurred(event_occurred), .card_clicked_address(card_clicked_address),
        .card_to_test_address(card_to_test_address), .card_test_state(card_test_state),
        .card_press_checker_en(en), .sym_addr(sym_addr), .sym_data(sym_data),
        .active_mask(active_mask), .revealed_mask(revealed_mask),
        .pairs_found(pairs_found), .moves(moves), .game_over(game_over)
    );

    int total = 0;
    int bad   = 0;

    // Card-level game model
    bit m_act [1:NUM];
    bit m_rev [1:NUM];
    int m_pairs, m_moves, m_half;
    bit m_over;

    function automatic logic [17:0] exp_act();
        logic [17:0] r = '0;
        for (int i = 1; i <= NUM; i++) r[i-1] = m_act[i];
        return r;
    endfunction

    function automatic logic [17:0] exp_rev();
        logic [17:0] r = '0;
        for (int i = 1; i <= NUM; i++) r[i-1] = m_rev[i];
        return r;
    endfunction

    function automatic logic [1:0] exp_state(input int a);
        if (a < 1 || a > NUM) return 2'b00;
        return {m_rev[a], m_act[a]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        num_of_cards = 5'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= NUM; i++) begin
            m_act[i] = ((n % 2) == 0 && n >= 2 && n <= NUM && i <= n);
            m_rev[i] = 1'b0;
        end
        m_pairs = 0;
        m_moves = 0;
        m_half  = ((n % 2) == 0 && n >= 2 && n <= NUM) ? n / 2 : 0;
        m_over  = 1'b0;
    endtask

    task automatic click(input int a, output bit acc);
        acc = (a >= 1 && a <= NUM) ? (m_act[a] && !m_rev[a]) : 1'b0;
        card_clicked_address = 5'(a);
        event_occurred = 1'b1;
        tick();
        event_occurred = 1'b0;
        if (acc) m_rev[a] = 1'b1;
    endtask

    // Spend the fetch/compare/show cycles with spurious clicks, stopping one
    // cycle before the resolved board becomes visible.
    task automatic hold_until_resolve();
        for (int k = 0; k < D + 2; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                card_clicked_address = 5'($urandom_range(0, 31));
                event_occurred = 1'b1;
            end
            tick();
            event_occurred = 1'b0;
        end
    endtask

    task automatic model_resolve(input int a1, input int a2);
        if (m_moves < 255) m_moves++;
        m_rev[a1] = 1'b0;
        m_rev[a2] = 1'b0;
        if (deck[a1] == deck[a2]) begin
            m_act[a1] = 1'b0;
            m_act[a2] = 1'b0;
            m_pairs++;
        end
        m_over = (m_pairs == m_half);
    endtask

    task automatic set_deck4();
        for (int i = 0; i < 32; i++) deck[i] = 4'h0;
        deck[1] = 4'hA; deck[2] = 4'hB; deck[3] = 4'hA; deck[4] = 4'hB;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        card_to_test_address = 5'd1;
        tick(); tick();
        total++; if (active_mask !== 18'h0) begin bad++; $display("FAIL reset_active: got %h want 0", active_mask); end
        total++; if (revealed_mask !== 18'h0) begin bad++; $display("FAIL reset_revealed: got %h want 0", revealed_mask); end
        total++; if ({pairs_found, moves, game_over, en} !== 14'h0) begin bad++; $display("FAIL reset_counters: got %h want 0", {pairs_found, moves, game_over, en}); end
        total++; if ({sym_addr, card_test_state} !== 7'h0) begin bad++; $display("FAIL reset_addr_state: got %h want 0", {sym_addr, card_test_state}); end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_start();
        set_deck4();
        do_start(4);
        total++; if (active_mask !== 18'h0000F) begin bad++; $display("FAIL start_active: got %h want 0000f", active_mask); end
        total++; if (revealed_mask !== 18'h0) begin bad++; $display("FAIL start_revealed: got %h want 0", revealed_mask); end
        total++; if (en !== 1'b1) begin bad++; $display("FAIL start_en: got %b want 1", en); end
        card_to_test_address = 5'd2; #1;
        total++; if (card_test_state !== 2'b01) begin bad++; $display("FAIL test_state_a2: got %b want 01", card_test_state); end
        card_to_test_address = 5'd0; #1;
        total++; if (card_test_state !== 2'b00) begin bad++; $display("FAIL test_state_a0: got %b want 00", card_test_state); end
    endtask

    task automatic test_match();
        bit acc;
        click(1, acc); tick();
        click(3, acc);
        tick(); tick();   // now in the first SHOW cycle
        total++; if (revealed_mask !== 18'h00005 || en !== 1'b0) begin bad++; $display("FAIL match_show: got rev=%h en=%b want rev=00005 en=0", revealed_mask, en); end
        total++; if (moves !== 8'd1) begin bad++; $display("FAIL match_moves_early: got %0d want 1", moves); end
        for (int k = 0; k < D; k++) tick();   // RESOLVE cycle, board not yet updated
        total++; if (active_mask !== 18'h0000F || revealed_mask !== 18'h00005) begin bad++; $display("FAIL match_hold: got act=%h rev=%h want act=0000f rev=00005", active_mask, revealed_mask); end
        tick();
        model_resolve(1, 3);
        total++; if (active_mask !== 18'h0000A || revealed_mask !== 18'h0) begin bad++; $display("FAIL match_masks: got act=%h rev=%h want act=0000a rev=0", active_mask, revealed_mask); end
        total++; if (pairs_found !== 4'd1 || moves !== 8'd1 || en !== 1'b1) begin bad++; $display("FAIL match_counts: got pairs=%0d moves=%0d en=%b want 1 1 1", pairs_found, moves, en); end
    endtask

    task automatic test_mismatch();
        bit acc;
        do_start(4);
        click(1, acc); tick();
        click(2, acc);
        hold_until_resolve(); tick();
        model_resolve(1, 2);
        total++; if (revealed_mask !== 18'h0 || active_mask !== 18'h0000F) begin bad++; $display("FAIL mismatch_masks: got act=%h rev=%h want act=0000f rev=0", active_mask, revealed_mask); end
        total++; if (pairs_found !== 4'd0 || moves !== 8'd1) begin bad++; $display("FAIL mismatch_counts: got pairs=%0d moves=%0d want 0 1", pairs_found, moves); end
    endtask

    task automatic test_ignore_and_finish();
        bit acc;
        do_start(4);
        click(1, acc); tick();
        click(1, acc);
        total++; if (revealed_mask !== 18'h00001 || en !== 1'b1) begin bad++; $display("FAIL ignore_same: got rev=%h en=%b want 00001 1", revealed_mask, en); end
        click(20, acc);
        total++; if (revealed_mask !== 18'h00001 || en !== 1'b1) begin bad++; $display("FAIL ignore_range: got rev=%h en=%b want 00001 1", revealed_mask, en); end
        click(3, acc); hold_until_resolve(); tick(); model_resolve(1, 3);
        click(2, acc); tick();
        click(4, acc); hold_until_resolve(); tick(); model_resolve(2, 4);
        total++; if (game_over !== 1'b1 || en !== 1'b0) begin bad++; $display("FAIL finish_flags: got over=%b en=%b want 1 0", game_over, en); end
        total++; if (pairs_found !== 4'd2 || moves !== 8'd2) begin bad++; $display("FAIL finish_counts: got pairs=%0d moves=%0d want 2 2", pairs_found, moves); end
        do_start(5);
        total++; if (active_mask !== 18'h0 || revealed_mask !== 18'h0 || en !== 1'b0 || game_over !== 1'b0) begin bad++; $display("FAIL bad_count: got act=%h rev=%h en=%b over=%b want all 0", active_mask, revealed_mask, en, game_over); end
    endtask

    task automatic test_start_wins();
        num_of_cards = 5'd4;
        card_clicked_address = 5'd1;
        start = 1'b1;
        event_occurred = 1'b1;
        tick();
        start = 1'b0;
        event_occurred = 1'b0;
        total++; if (active_mask !== 18'h0000F || revealed_mask !== 18'h0 || en !== 1'b1) begin bad++; $display("FAIL start_wins: got act=%h rev=%h en=%b want 0000f 0 1", active_mask, revealed_mask, en); end
    endtask

    task automatic test_reset_mid_show();
        bit acc;
        do_start(4);
        click(1, acc); tick();
        click(2, acc); tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        total++; if ({active_mask, revealed_mask} !== 36'h0) begin bad++; $display("FAIL async_reset_masks: got act=%h rev=%h want 0", active_mask, revealed_mask); end
        total++; if ({pairs_found, moves, game_over, en, card_test_state} !== 16'h0) begin bad++; $display("FAIL async_reset_outs: got moves=%0d en=%b want 0", moves, en); end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_moves_saturate();
        bit acc;
        set_deck4();
        do_start(4);
        for (int k = 1; k <= 256; k++) begin
            click(1, acc); tick();
            click(2, acc); hold_until_resolve(); tick();
            model_resolve(1, 2);
            total++; if (moves !== 8'(m_moves)) begin bad++; $display("FAIL moves_sat[%0d]: got %0d want %0d", k, moves, m_moves); end
        end
        total++; if (moves !== 8'd255) begin bad++; $display("FAIL moves_final: got %0d want 255", moves); end
    endtask

    task automatic test_random_games();
        bit acc;
        int n, a, first, tmp, j, q;
        bit have_first;
        for (int g = 0; g < 6; g++) begin
            n = 2 * int'($urandom_range(1, 9));
            for (int i = 0; i < 32; i++) deck[i] = 4'($urandom_range(0, 15));
            for (int p = 0; p < n / 2; p++) begin
                deck[2*p+1] = 4'($urandom_range(0, 15));
                deck[2*p+2] = deck[2*p+1];
            end
            for (int i = n; i > 1; i--) begin
                j = int'($urandom_range(1, i));
                tmp = deck[i]; deck[i] = deck[j]; deck[j] = 4'(tmp);
            end
            do_start(n);
            total++; if (active_mask !== exp_act()) begin bad++; $display("FAIL rnd_start_active: got %h want %h", active_mask, exp_act()); end
            have_first = 1'b0;
            first = 0;
            for (int c = 0; c < 500 && !m_over; c++) begin
                a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, n));
                click(a, acc);
                if (!acc) begin
                    total++; if (revealed_mask !== exp_rev() || en !== 1'b1) begin bad++; $display("FAIL rnd_ignored: got rev=%h en=%b want %h 1", revealed_mask, en, exp_rev()); end
                end else if (!have_first) begin
                    have_first = 1'b1;
                    first = a;
                    tick();
                    total++; if (revealed_mask !== exp_rev()) begin bad++; $display("FAIL rnd_first: got %h want %h", revealed_mask, exp_rev()); end
                end else begin
                    have_first = 1'b0;
                    hold_until_resolve(); tick();
                    model_resolve(first, a);
                    total++; if (active_mask !== exp_act() || revealed_mask !== exp_rev()) begin bad++; $display("FAIL rnd_resolve: got act=%h rev=%h want act=%h rev=%h", active_mask, revealed_mask, exp_act(), exp_rev()); end
                    total++; if (pairs_found !== 4'(m_pairs) || moves !== 8'(m_moves) || game_over !== m_over || en !== !m_over) begin bad++; $display("FAIL rnd_counts: got pairs=%0d moves=%0d over=%b want %0d %0d %b", pairs_found, moves, game_over, m_pairs, m_moves, m_over); end
                end
                q = int'($urandom_range(0, 31));
                card_to_test_address = 5'(q); #1;
                total++; if (card_test_state !== exp_state(q)) begin bad++; $display("FAIL rnd_query[%0d]: got %b want %b", q, card_test_state, exp_state(q)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_match();
        test_mismatch();
        test_ignore_and_finish();
        test_start_wins();
        test_reset_mid_show();
        test_moves_saturate();
        test_random_games();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
